inst_mem_responder: RTL

Instruction-memory responder serving the fetch side of the single-cycle ysyx_25020047 core: it accepts a PC-addressed fetch request, waits a programmable number of cycles, and returns the 32-bit instruction word over a valid/ready response channel. It holds a word-addressed instruction store that a simulation loader port fills. Out-of-range or misaligned fetches complete with an error flag and an `ebreak` word.

---
 rtl/inst_mem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// inst_mem_responder
//   Instruction-fetch responder. Accepts one PC-addressed request at a time,
//   waits LAT cycles, then presents the instruction word (or an ebreak with
//   rsp_err set for misaligned / out-of-range fetches) on a valid/ready
//   response channel. The word store is filled through the loader port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req_valid  fetch request valid
//   req_ready  responder idle and able to accept a request
//   req_addr   fetch byte address, sampled only at acceptance
//   rsp_valid  response valid
//   rsp_ready  consumer accepts response
//   rsp_inst   instruction word (held while rsp_valid)
//   rsp_err    fetch fault flag
//   ld_en      loader write strobe
//   ld_idx     loader word index
//   ld_data    loader write data
module inst_mem_responder #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic          rsp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_inst_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic        fetch_err_d;
    logic [31:0] fetch_inst_d;

    // Wrapping subtraction makes addresses below BASE land far out of range.
    always_comb begin
        off          = req_addr - BASE;
        fetch_err_d  = (req_addr[1:0] != 2'b00) || (off >= SPAN);
        fetch_inst_d = fetch_err_d ? EBREAK : mem[off[AW+1:2]];
    end

    // No reset: contents survive reset. The FSM reads mem in the same edge
    // that a loader write lands, so a colliding accept sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        rsp_inst_q <= fetch_inst_d;
                        rsp_err_q  <= fetch_err_d;
                        if (LAT > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LAT);
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated with rst so ready drops during reset yet is high in the very
    // first cycle after release, without waiting for a clock edge.
    assign req_ready = rst && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

endmodule
